parking_lot_controller: RTL

- Sequencing controller for the 8-space parking lot: owns the occupancy register, allocates spaces to entering cars, releases spaces for exiting cars, and drives the shared barrier gate.
- Entry and exit requests compete for one gate. Exit has priority.
- park_location is the occupancy vector consumed by the display and exit-decode logic. Bit i = 1 means space i is occupied.

---
 rtl/parking_lot_controller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/parking_lot_controller.sv
// Eight-space parking lot sequencer: occupancy register, space allocation/release and shared gate timing.
// Optional entry statistics counters are compiled in with `define PARK_STATS_EN.
module parking_lot_controller #(
    parameter int GATE_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter_req,
    input  logic             exit_req,
    input  logic [2:0]       exit_number,
    output logic [7:0]       park_location,
    output logic [2:0]       assigned_number,
    output logic             enter_ack,
    output logic             enter_nack,
    output logic             exit_ack,
    output logic             exit_err,
    output logic             gate_open,
    output logic             full,
    output logic             empty,
    output logic [3:0]       free_count,
    output logic [1:0]       fsm_state
`ifdef PARK_STATS_EN
    ,
    output logic [7:0]       total_entries,
    output logic [7:0]       refused_entries
`endif
);

    // Handshake: a request is a level held by the requester until its one-cycle
    // ack/nack pulse; the controller then waits for that same line to drop before
    // it will sample any request again, so a held level is never serviced twice.

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GATE     = 2'd1;
    localparam logic [1:0] WAIT_REL = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] timer;
    logic             svc_exit;
    logic [2:0]       free_idx;
    logic [3:0]       occ_cnt;
    logic             exit_hit;
    logic             do_exit;
    logic             do_alloc;
    logic             do_refuse;

    assign fsm_state = state;
    assign full      = &park_location;
    assign empty     = ~|park_location;
    assign exit_hit  = park_location[exit_number];

    // Exit requests take priority over entry requests on the same IDLE edge.
    assign do_exit   = (state == IDLE) && exit_req;
    assign do_alloc  = (state == IDLE) && !exit_req && enter_req && !full;
    assign do_refuse = (state == IDLE) && !exit_req && enter_req && full;

    always_comb begin
        free_idx = 3'd0;
        occ_cnt  = 4'd0;
        // Descending scan leaves the lowest-index free space in free_idx.
        for (int i = 7; i >= 0; i--) begin
            if (!park_location[i]) begin
                free_idx = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            occ_cnt = occ_cnt + 4'(park_location[i]);
        end
        free_count = 4'd8 - occ_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            svc_exit        <= 1'b0;
            park_location   <= 8'h00;
            assigned_number <= 3'd0;
            enter_ack       <= 1'b0;
            enter_nack      <= 1'b0;
            exit_ack        <= 1'b0;
            exit_err        <= 1'b0;
            gate_open       <= 1'b0;
        end else begin
            enter_ack  <= 1'b0;
            enter_nack <= 1'b0;
            exit_ack   <= 1'b0;
            exit_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_exit) begin
                        svc_exit <= 1'b1;
                        exit_ack <= 1'b1;
                        if (exit_hit) begin
                            park_location[exit_number] <= 1'b0;
                            timer     <= CNT_W'(GATE_CYCLES);
                            gate_open <= 1'b1;
                            state     <= GATE;
                        end else begin
                            exit_err <= 1'b1;
                            state    <= WAIT_REL;
                        end
                    end else if (do_alloc) begin
                        svc_exit                <= 1'b0;
                        enter_ack               <= 1'b1;
                        park_location[free_idx] <= 1'b1;
                        assigned_number         <= free_idx;
                        timer                   <= CNT_W'(GATE_CYCLES);
                        gate_open               <= 1'b1;
                        state                   <= GATE;
                    end else if (do_refuse) begin
                        svc_exit   <= 1'b0;
                        enter_nack <= 1'b1;
                        state      <= WAIT_REL;
                    end
                end
                GATE: begin
                    // gate_open was raised on entry, so the last open cycle is timer==1.
                    if (timer <= CNT_W'(1)) begin
                        timer     <= '0;
                        gate_open <= 1'b0;
                        state     <= WAIT_REL;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (svc_exit ? !exit_req : !enter_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    gate_open <= 1'b0;
                    timer     <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef PARK_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_entries   <= 8'h00;
            refused_entries <= 8'h00;
        end else begin
            if (do_alloc && total_entries != 8'hFF) begin
                total_entries <= total_entries + 8'd1;
            end
            if (do_refuse && refused_entries != 8'hFF) begin
                refused_entries <= refused_entries + 8'd1;
            end
        end
    end
`endif

endmodule
